// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
// control_sequencer
//
// Hardwired Moore control unit for a small 32-bit bus-based CPU. It runs a
// three-step fetch (T0..T2) and then up to five execute steps (EX1..EX5),
// according to the opcode in ir[31:27]. Every control output comes from a
// register, so the strobes change only on a rising clk edge or on clr.
//
// Ports
//   clk                  single clock, rising-edge active
//   clr                  asynchronous active-high reset
//   ir[31:0]             instruction register, opcode = ir[31:27]
//   con_ff               branch condition flag from the datapath
//   stop                 halt request, checked on the last execute step
//   pc_out, zlo_out, mdr_out, c_sign_extended_out, r_out
//                        bus drivers, at most one is active per state
//   ba_out               base-address read of the selected register (R0 = 0)
//   r_in                 write the selected register
//   gr_sel[2:0]          one-hot register field select {gra, grb, grc}
//   mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable,
//   r8_enable, con_enable
//                        register load enables
//   read                 MDR source select (1 = memory, 0 = bus)
//   ram_write            memory write strobe
//   pc_increment         ALU computes PC+1
//   alu_op[4:0]          ALU operation, ADD except on add/sub EX2
//   run                  high while executing, low in reset and in HALT
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        mdr_out,
  output logic        c_sign_extended_out,
  output logic        r_out,
  output logic        ba_out,
  output logic        r_in,
  output logic [2:0]  gr_sel,
  output logic        mar_enable,
  output logic        mdr_enable,
  output logic        read,
  output logic        ram_write,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        z_enable,
  output logic        pc_enable,
  output logic        pc_increment,
  output logic        r8_enable,
  output logic        con_enable,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_EX1,
    ST_EX2,
    ST_EX3,
    ST_EX4,
    ST_EX5,
    ST_HALT
  } state_t;

  // All registered control outputs, kept together so that one decode
  // function produces the complete control word of a state.
  typedef struct packed {
    logic       pc_out;
    logic       zlo_out;
    logic       mdr_out;
    logic       c_sign_extended_out;
    logic       r_out;
    logic       ba_out;
    logic       r_in;
    logic [2:0] gr_sel;
    logic       mar_enable;
    logic       mdr_enable;
    logic       read;
    logic       ram_write;
    logic       ir_enable;
    logic       y_enable;
    logic       z_enable;
    logic       pc_enable;
    logic       pc_increment;
    logic       r8_enable;
    logic       con_enable;
    logic [4:0] alu_op;
    logic       run;
  } ctl_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JAL  = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  localparam logic [2:0] GRA = 3'b100;
  localparam logic [2:0] GRB = 3'b010;
  localparam logic [2:0] GRC = 3'b001;

  state_t     state;
  state_t     state_next;
  logic [4:0] opcode;
  logic [4:0] op_next;
  ctl_t       ctl;

  // Only the opcode field of ir matters here; the remaining bits feed the
  // datapath directly.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  // Number of execute steps per opcode; nop and every undefined opcode
  // have none and return straight from T2 to T0.
  function automatic logic [2:0] exec_len(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:          exec_len = 3'd5;
      OP_LDI, OP_ADD, OP_SUB: exec_len = 3'd3;
      OP_BR:                 exec_len = 3'd4;
      OP_JAL:                exec_len = 3'd2;
      OP_JR:                 exec_len = 3'd1;
      default:               exec_len = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] ex_step(input state_t st);
    case (st)
      ST_EX1:  ex_step = 3'd1;
      ST_EX2:  ex_step = 3'd2;
      ST_EX3:  ex_step = 3'd3;
      ST_EX4:  ex_step = 3'd4;
      ST_EX5:  ex_step = 3'd5;
      default: ex_step = 3'd0;
    endcase
  endfunction

  // Control word for a given state and opcode. cond only matters for the
  // final step of br, where it gates the PC load.
  function automatic ctl_t decode(input state_t st, input logic [4:0] op,
                                  input logic cond);
    ctl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    c.run    = 1'b1;
    case (st)
      ST_RST: c = '0;
      ST_HALT: c.run = 1'b0;
      ST_T0: begin
        c.pc_out       = 1'b1;
        c.mar_enable   = 1'b1;
        c.pc_increment = 1'b1;
        c.z_enable     = 1'b1;
      end
      ST_T1: begin
        c.zlo_out    = 1'b1;
        c.pc_enable  = 1'b1;
        c.read       = 1'b1;
        c.mdr_enable = 1'b1;
      end
      ST_T2: begin
        c.mdr_out   = 1'b1;
        c.ir_enable = 1'b1;
      end
      default: begin
        case (op)
          OP_LDI, OP_LD, OP_ST: begin
            case (st)
              ST_EX1: begin
                c.gr_sel   = GRB;
                c.ba_out   = 1'b1;
                c.y_enable = 1'b1;
              end
              ST_EX2: begin
                c.c_sign_extended_out = 1'b1;
                c.z_enable            = 1'b1;
              end
              ST_EX3: begin
                c.zlo_out = 1'b1;
                if (op == OP_LDI) begin
                  c.gr_sel = GRA;
                  c.r_in   = 1'b1;
                end else begin
                  c.mar_enable = 1'b1;
                end
              end
              ST_EX4: begin
                c.mdr_enable = 1'b1;
                if (op == OP_LD) begin
                  c.read = 1'b1;
                end else begin
                  c.gr_sel = GRA;
                  c.r_out  = 1'b1;
                end
              end
              ST_EX5: begin
                if (op == OP_LD) begin
                  c.mdr_out = 1'b1;
                  c.gr_sel  = GRA;
                  c.r_in    = 1'b1;
                end else begin
                  c.ram_write = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_ADD, OP_SUB: begin
            case (st)
              ST_EX1: begin
                c.gr_sel   = GRB;
                c.r_out    = 1'b1;
                c.y_enable = 1'b1;
              end
              ST_EX2: begin
                c.gr_sel   = GRC;
                c.r_out    = 1'b1;
                c.z_enable = 1'b1;
                c.alu_op   = op;
              end
              ST_EX3: begin
                c.zlo_out = 1'b1;
                c.gr_sel  = GRA;
                c.r_in    = 1'b1;
              end
              default: ;
            endcase
          end
          OP_BR: begin
            case (st)
              ST_EX1: begin
                c.gr_sel     = GRA;
                c.r_out      = 1'b1;
                c.con_enable = 1'b1;
              end
              ST_EX2: begin
                c.pc_out   = 1'b1;
                c.y_enable = 1'b1;
              end
              ST_EX3: begin
                c.c_sign_extended_out = 1'b1;
                c.z_enable            = 1'b1;
              end
              ST_EX4: begin
                c.zlo_out   = 1'b1;
                c.pc_enable = cond;
              end
              default: ;
            endcase
          end
          OP_JR: begin
            if (st == ST_EX1) begin
              c.gr_sel    = GRA;
              c.r_out     = 1'b1;
              c.pc_enable = 1'b1;
            end
          end
          OP_JAL: begin
            case (st)
              ST_EX1: begin
                c.pc_out    = 1'b1;
                c.r8_enable = 1'b1;
              end
              ST_EX2: begin
                c.gr_sel    = GRA;
                c.r_out     = 1'b1;
                c.pc_enable = 1'b1;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    endcase
    return c;
  endfunction

  // Next-state selection. In T2 the opcode is taken straight from ir, since
  // that is the value being latched on the same edge.
  always_comb begin
    op_next    = (state == ST_T2) ? ir[31:27] : opcode;
    state_next = state;
    case (state)
      ST_RST: state_next = ST_T0;
      ST_T0:  state_next = ST_T1;
      ST_T1:  state_next = ST_T2;
      ST_T2: begin
        if (op_next == OP_HALT) begin
          state_next = ST_HALT;
        end else if (exec_len(op_next) == 3'd0) begin
          state_next = ST_T0;
        end else begin
          state_next = ST_EX1;
        end
      end
      ST_EX1, ST_EX2, ST_EX3, ST_EX4, ST_EX5: begin
        if (ex_step(state) >= exec_len(opcode)) begin
          state_next = stop ? ST_HALT : ST_T0;
        end else begin
          state_next = state_t'(state + 4'd1);
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase
  end

  // State, latched opcode and the registered control word. The control word
  // is decoded for the state being entered, so the outputs line up with the
  // state for the whole cycle. The br PC load samples con_ff on the edge
  // into EX4; CON FF was loaded back in EX1, so it is stable by then.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= ST_RST;
      opcode <= 5'b00000;
      ctl    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_T2) begin
        opcode <= ir[31:27];
      end
      ctl <= decode(state_next, op_next, con_ff);
    end
  end

  assign pc_out              = ctl.pc_out;
  assign zlo_out             = ctl.zlo_out;
  assign mdr_out             = ctl.mdr_out;
  assign c_sign_extended_out = ctl.c_sign_extended_out;
  assign r_out               = ctl.r_out;
  assign ba_out              = ctl.ba_out;
  assign r_in                = ctl.r_in;
  assign gr_sel              = ctl.gr_sel;
  assign mar_enable          = ctl.mar_enable;
  assign mdr_enable          = ctl.mdr_enable;
  assign read                = ctl.read;
  assign ram_write           = ctl.ram_write;
  assign ir_enable           = ctl.ir_enable;
  assign y_enable            = ctl.y_enable;
  assign z_enable            = ctl.z_enable;
  assign pc_enable           = ctl.pc_enable;
  assign pc_increment        = ctl.pc_increment;
  assign r8_enable           = ctl.r8_enable;
  assign con_enable          = ctl.con_enable;
  assign alu_op              = ctl.alu_op;
  assign run                 = ctl.run;

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
// tb_control_sequencer
//
// Directed and randomized bench for control_sequencer. The reference model
// is a per-opcode micro-step table: each instruction expands into a list of
// expected control words (fetch, then its execute steps), which is compared
// with the DUT outputs one clock at a time.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic        pc_out, zlo_out, mdr_out, c_sign_extended_out, r_out;
  logic        ba_out, r_in;
  logic [2:0]  gr_sel;
  logic        mar_enable, mdr_enable, read, ram_write, ir_enable;
  logic        y_enable, z_enable, pc_enable, pc_increment, r8_enable;
  logic        con_enable;
  logic [4:0]  alu_op;
  logic        run;

  typedef struct packed {
    logic       pc_out;
    logic       zlo_out;
    logic       mdr_out;
    logic       csext;
    logic       r_out;
    logic       ba_out;
    logic       r_in;
    logic [2:0] gr;
    logic       mar;
    logic       mdr;
    logic       read;
    logic       ram_write;
    logic       ir_en;
    logic       y;
    logic       z;
    logic       pc_en;
    logic       pc_inc;
    logic       r8;
    logic       con_en;
    logic [4:0] alu;
    logic       run;
  } word_t;

  int    vectors;
  int    miscompares;
  word_t expQ[$];

  control_sequencer dut (
    .clk                 (clk),
    .clr                 (clr),
    .ir                  (ir),
    .con_ff              (con_ff),
    .stop                (stop),
    .pc_out              (pc_out),
    .zlo_out             (zlo_out),
    .mdr_out             (mdr_out),
    .c_sign_extended_out (c_sign_extended_out),
    .r_out               (r_out),
    .ba_out              (ba_out),
    .r_in                (r_in),
    .gr_sel              (gr_sel),
    .mar_enable          (mar_enable),
    .mdr_enable          (mdr_enable),
    .read                (read),
    .ram_write           (ram_write),
    .ir_enable           (ir_enable),
    .y_enable            (y_enable),
    .z_enable            (z_enable),
    .pc_enable           (pc_enable),
    .pc_increment        (pc_increment),
    .r8_enable           (r8_enable),
    .con_enable          (con_enable),
    .alu_op              (alu_op),
    .run                 (run)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // An executing step with nothing asserted: ALU on ADD, run high.
  function automatic word_t busy();
    word_t w;
    w     = '0;
    w.alu = 5'b00011;
    w.run = 1'b1;
    return w;
  endfunction

  function automatic word_t haltWord();
    word_t w;
    w     = '0;
    w.alu = 5'b00011;
    return w;
  endfunction

  // Expand one instruction into its sequence of expected control words.
  task automatic buildProgram(input logic [4:0] op, input logic cond);
    word_t w;
    expQ.delete();
    w = busy(); w.pc_out = 1; w.mar = 1; w.pc_inc = 1; w.z = 1; expQ.push_back(w);
    w = busy(); w.zlo_out = 1; w.pc_en = 1; w.read = 1; w.mdr = 1; expQ.push_back(w);
    w = busy(); w.mdr_out = 1; w.ir_en = 1; expQ.push_back(w);
    if (op == 5'd0 || op == 5'd1 || op == 5'd2) begin
      w = busy(); w.gr = 3'b010; w.ba_out = 1; w.y = 1; expQ.push_back(w);
      w = busy(); w.csext = 1; w.z = 1; expQ.push_back(w);
      if (op == 5'd1) begin
        w = busy(); w.zlo_out = 1; w.gr = 3'b100; w.r_in = 1; expQ.push_back(w);
      end else begin
        w = busy(); w.zlo_out = 1; w.mar = 1; expQ.push_back(w);
        if (op == 5'd0) begin
          w = busy(); w.read = 1; w.mdr = 1; expQ.push_back(w);
          w = busy(); w.mdr_out = 1; w.gr = 3'b100; w.r_in = 1; expQ.push_back(w);
        end else begin
          w = busy(); w.gr = 3'b100; w.r_out = 1; w.mdr = 1; expQ.push_back(w);
          w = busy(); w.ram_write = 1; expQ.push_back(w);
        end
      end
    end else if (op == 5'd3 || op == 5'd4) begin
      w = busy(); w.gr = 3'b010; w.r_out = 1; w.y = 1; expQ.push_back(w);
      w = busy(); w.gr = 3'b001; w.r_out = 1; w.z = 1; w.alu = op; expQ.push_back(w);
      w = busy(); w.zlo_out = 1; w.gr = 3'b100; w.r_in = 1; expQ.push_back(w);
    end else if (op == 5'd18) begin
      w = busy(); w.gr = 3'b100; w.r_out = 1; w.con_en = 1; expQ.push_back(w);
      w = busy(); w.pc_out = 1; w.y = 1; expQ.push_back(w);
      w = busy(); w.csext = 1; w.z = 1; expQ.push_back(w);
      w = busy(); w.zlo_out = 1; w.pc_en = cond; expQ.push_back(w);
    end else if (op == 5'd20) begin
      w = busy(); w.gr = 3'b100; w.r_out = 1; w.pc_en = 1; expQ.push_back(w);
    end else if (op == 5'd19) begin
      w = busy(); w.pc_out = 1; w.r8 = 1; expQ.push_back(w);
      w = busy(); w.gr = 3'b100; w.r_out = 1; w.pc_en = 1; expQ.push_back(w);
    end
  endtask

  function automatic word_t sampleDut();
    word_t o;
    o.pc_out    = pc_out;
    o.zlo_out   = zlo_out;
    o.mdr_out   = mdr_out;
    o.csext     = c_sign_extended_out;
    o.r_out     = r_out;
    o.ba_out    = ba_out;
    o.r_in      = r_in;
    o.gr        = gr_sel;
    o.mar       = mar_enable;
    o.mdr       = mdr_enable;
    o.read      = read;
    o.ram_write = ram_write;
    o.ir_en     = ir_enable;
    o.y         = y_enable;
    o.z         = z_enable;
    o.pc_en     = pc_enable;
    o.pc_inc    = pc_increment;
    o.r8        = r8_enable;
    o.con_en    = con_enable;
    o.alu       = alu_op;
    o.run       = run;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input word_t expected);
    word_t observed;
    observed = sampleDut();
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Run one instruction from its T0 onwards. Inputs are changed only after
  // the T0 check so the previous instruction's last edge is undisturbed.
  // abortStep >= 0 raises clr right after that step has been checked.
  task automatic applyStimulus(input string tag, input logic [31:0] irVal,
                               input logic stopVal, input logic conVal,
                               input int abortStep);
    buildProgram(irVal[31:27], conVal);
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s step%0d", tag, i), expQ[i]);
      if (i == 0) begin
        ir     = irVal;
        stop   = stopVal;
        con_ff = conVal;
      end
      if (i == abortStep) begin
        clr = 1'b1;
        #1;
        checkOutput($sformatf("%s async clr", tag), '0);
        @(negedge clk);
        checkOutput($sformatf("%s held clr", tag), '0);
        clr = 1'b0;
        break;
      end
    end
  endtask

  task automatic checkHalted(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s halt%0d", tag, i), haltWord());
    end
  endtask

  task automatic recover(input string tag);
    @(negedge clk);
    clr = 1'b1;
    #1;
    checkOutput($sformatf("%s clr", tag), '0);
    @(negedge clk);
    clr  = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    logic [4:0] pool [9];
    logic [4:0] undef [6];
    logic [4:0] op;
    vectors     = 0;
    miscompares = 0;
    pool  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd18, 5'd19, 5'd20, 5'd26};
    undef = '{5'd5, 5'd9, 5'd17, 5'd21, 5'd25, 5'd30};
    clr    = 1'b1;
    ir     = 32'h0;
    con_ff = 1'b0;
    stop   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", '0);
    clr = 1'b0;

    applyStimulus("ldi", 32'h0800_0005, 1'b0, 1'b0, -1);
    applyStimulus("jal", 32'h9800_0000, 1'b0, 1'b0, -1);
    applyStimulus("br0", 32'h9000_0010, 1'b0, 1'b0, -1);
    applyStimulus("br1", 32'h9000_0010, 1'b0, 1'b1, -1);
    applyStimulus("st",  32'h1000_0003, 1'b0, 1'b0, -1);
    applyStimulus("nop", 32'hD000_0000, 1'b0, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) op = undef[$urandom_range(0, 5)];
      else op = pool[$urandom_range(0, 8)];
      applyStimulus($sformatf("rnd%0d op%0d", n, op),
                    {op, 27'($urandom())}, 1'b0, 1'($urandom()), -1);
    end

    applyStimulus("add stop", 32'h1884_0000, 1'b1, 1'b0, -1);
    checkHalted("add stop", 12);
    recover("add stop");

    applyStimulus("halt", 32'hD800_0000, 1'b0, 1'b0, -1);
    checkHalted("halt", 12);
    recover("halt");

    applyStimulus("ld abort", 32'h0080_0007, 1'b0, 1'b0, 6);
    applyStimulus("refetch", 32'h2000_0000, 1'b0, 1'b0, -1);
    applyStimulus("tail", 32'h0800_0001, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
